// File: rtl/fifo_fc_param.sv
// fifo_fc_param: flow-controlled FIFO with an explicit occupancy counter,
// hysteresis almost-full flow control, overflow/underflow flags and an
// optional sticky ERROR state. Read data is registered (1-cycle latency).
module fifo_fc_param #(
  parameter int AW         = 3,
  parameter int DW         = 8,
  parameter int STICKY_ERR = 1
) (
  input  logic          clk,
  input  logic          reset,
  input  logic [DW-1:0] data_in,
  input  logic          push,
  input  logic          pop,
  input  logic [AW:0]   umbral_almost_full,
  input  logic [AW:0]   umbral_almost_empty,
  output logic [DW-1:0] data_out,
  output logic          valid_out,
  output logic          fifo_empty,
  output logic          fifo_full,
  output logic          almost_full,
  output logic [AW:0]   fill_level,
  output logic          error,
  output logic          overflow,
  output logic          underflow
);

  localparam int DEPTH = 1 << AW;
  localparam logic [AW:0] FULL_CNT = {1'b1, {AW{1'b0}}};

  typedef enum logic [1:0] {
    ST_EMPTY,
    ST_ACTIVE,
    ST_PAUSE,
    ST_ERROR
  } state_t;

  logic [DW-1:0] mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [AW:0]   count, count_next, af_thr;
  state_t        state, state_next;
  logic          push_acc, pop_acc, ovf_evt, unf_evt, err_evt;

  // Acceptance, rejection events and next occupancy, all from registered count.
  // NOTE: every signal written here gets a default first so no latch is inferred.
  always_comb begin
    pop_acc  = pop && (count != '0) && (state != ST_ERROR);
    push_acc = push && ((count != FULL_CNT) || pop_acc) && (state != ST_ERROR);
    ovf_evt  = push && !push_acc && (state != ST_ERROR);
    unf_evt  = pop && !pop_acc && (state != ST_ERROR);
    err_evt  = ovf_evt || unf_evt;
    count_next = count;
    if (push_acc && !pop_acc)
      count_next = count + 1'b1;
    else if (!push_acc && pop_acc)
      count_next = count - 1'b1;
    // A zero entry threshold means PAUSE is never entered.
    af_thr = (umbral_almost_full == '0) ? FULL_CNT + 1'b1 : umbral_almost_full;
  end

  // Pointers, occupancy, registered read data and error flags.
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge clk) begin
    if (!reset) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      data_out  <= '0;
      valid_out <= 1'b0;
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      count     <= count_next;
      valid_out <= pop_acc;
      overflow  <= ovf_evt;
      underflow <= unf_evt;
      if (push_acc)
        wr_ptr <= wr_ptr + 1'b1;
      if (pop_acc) begin
        rd_ptr   <= rd_ptr + 1'b1;
        data_out <= mem[rd_ptr];
      end
    end
  end

  // Storage array write port.
  // NOTE: the memory has no reset; pointers and count define what is valid.
  always_ff @(posedge clk) begin
    if (push_acc)
      mem[wr_ptr] <= data_in;
  end

  // FSM state register.
  always_ff @(posedge clk) begin
    if (!reset)
      state <= ST_EMPTY;
    else
      state <= state_next;
  end

  // FSM next state; the sticky error check overrides every other transition.
  always_comb begin
    state_next = state;
    if ((STICKY_ERR != 0) && err_evt) begin
      state_next = ST_ERROR;
    end else begin
      case (state)
        ST_EMPTY:
          if (count_next != '0) state_next = ST_ACTIVE;
        ST_ACTIVE:
          if (count_next >= af_thr)  state_next = ST_PAUSE;
          else if (count_next == '0) state_next = ST_EMPTY;
        ST_PAUSE:
          // Entry check wins when the exit threshold overlaps it.
          if (count_next >= af_thr)
            state_next = ST_PAUSE;
          else if (count_next <= umbral_almost_empty)
            state_next = (count_next == '0) ? ST_EMPTY : ST_ACTIVE;
        ST_ERROR:
          state_next = ST_ERROR;
        default:
          state_next = ST_EMPTY;
      endcase
    end
  end

  // FSM and status outputs decoded from registered state and count.
  always_comb begin
    almost_full = (state == ST_PAUSE);
    error       = (STICKY_ERR != 0) ? (state == ST_ERROR) : (overflow || underflow);
    fifo_empty  = (count == '0);
    fifo_full   = (count == FULL_CNT);
    fill_level  = count;
  end

endmodule

// File: tb/tb_fifo_fc_param.sv
// tb_fifo_fc_param: directed test of fifo_fc_param with one sticky-error
// instance (u_s) and one pulse-error instance (u_p) sharing the same inputs.
module tb_fifo_fc_param;

  logic       clk = 1'b0;
  logic       reset;
  logic [7:0] data_in;
  logic       push, pop;
  logic [3:0] umbral_almost_full, umbral_almost_empty;

  logic [7:0] s_data_out, p_data_out;
  logic       s_valid, s_empty, s_full, s_af, s_err, s_ovf, s_unf;
  logic       p_valid, p_empty, p_full, p_af, p_err, p_ovf, p_unf;
  logic [3:0] s_fill, p_fill;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  fifo_fc_param #(.AW(3), .DW(8), .STICKY_ERR(1)) u_s (
    .clk(clk), .reset(reset), .data_in(data_in), .push(push), .pop(pop),
    .umbral_almost_full(umbral_almost_full), .umbral_almost_empty(umbral_almost_empty),
    .data_out(s_data_out), .valid_out(s_valid), .fifo_empty(s_empty), .fifo_full(s_full),
    .almost_full(s_af), .fill_level(s_fill), .error(s_err), .overflow(s_ovf),
    .underflow(s_unf)
  );

  fifo_fc_param #(.AW(3), .DW(8), .STICKY_ERR(0)) u_p (
    .clk(clk), .reset(reset), .data_in(data_in), .push(push), .pop(pop),
    .umbral_almost_full(umbral_almost_full), .umbral_almost_empty(umbral_almost_empty),
    .data_out(p_data_out), .valid_out(p_valid), .fifo_empty(p_empty), .fifo_full(p_full),
    .almost_full(p_af), .fill_level(p_fill), .error(p_err), .overflow(p_ovf),
    .underflow(p_unf)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // Drive one cycle of stimulus; outputs are sampled 1 time unit after the edge.
  task automatic cyc(input logic ps, input logic pp, input logic [7:0] d);
    push    = ps;
    pop     = pp;
    data_in = d;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b0;
    cyc(1'b0, 1'b0, 8'h00);
    reset = 1'b1;
  endtask

  initial begin
    reset = 1'b0; push = 1'b0; pop = 1'b0; data_in = 8'h00;
    umbral_almost_full = 4'd6; umbral_almost_empty = 4'd2;

    // Reset state.
    cyc(1'b0, 1'b0, 8'h00);
    cyc(1'b0, 1'b0, 8'h00);
    check("rst_fill",  s_fill, 0);
    check("rst_empty", s_empty, 1);
    check("rst_full",  s_full, 0);
    check("rst_valid", s_valid, 0);
    check("rst_af",    s_af, 0);
    check("rst_err",   s_err, 0);
    check("rst_dout",  s_data_out, 0);
    reset = 1'b1;

    // Fill with 0xA1..0xA8; almost_full from the edge where count reaches 6.
    for (int i = 0; i < 8; i++) begin
      cyc(1'b1, 1'b0, 8'hA1 + 8'(i));
      check($sformatf("fill_lvl%0d", i), s_fill, i + 1);
      check($sformatf("fill_af%0d", i), s_af, (i + 1 >= 6) ? 1 : 0);
    end
    check("fill_full",  s_full, 1);
    check("fill_empty", s_empty, 0);
    check("fill_err",   s_err, 0);

    // Drain: 8 consecutive valid cycles, data in order; PAUSE exits at count 2.
    for (int i = 0; i < 8; i++) begin
      cyc(1'b0, 1'b1, 8'h00);
      check($sformatf("drain_valid%0d", i), s_valid, 1);
      check($sformatf("drain_data%0d", i), s_data_out, 8'hA1 + 8'(i));
      check($sformatf("drain_af%0d", i), s_af, (7 - i > 2) ? 1 : 0);
    end
    cyc(1'b0, 1'b0, 8'h00);
    check("drain_valid_end", s_valid, 0);
    check("drain_empty",     s_empty, 1);
    check("drain_hold",      s_data_out, 8'hA8);

    // Hysteresis: fill to 6, pop down to 2.
    for (int i = 0; i < 6; i++) cyc(1'b1, 1'b0, 8'h30 + 8'(i));
    check("hyst_af6", s_af, 1);
    for (int n = 5; n >= 2; n--) begin
      cyc(1'b0, 1'b1, 8'h00);
      check($sformatf("hyst_af_at%0d", n), s_af, (n > 2) ? 1 : 0);
      check($sformatf("hyst_lvl%0d", n), s_fill, n);
    end
    cyc(1'b0, 1'b1, 8'h00);
    cyc(1'b0, 1'b1, 8'h00);
    check("hyst_empty", s_empty, 1);

    // Wrap: 3 rounds of push 5 / pop 5.
    for (int r = 0; r < 3; r++) begin
      for (int k = 0; k < 5; k++) cyc(1'b1, 1'b0, 8'h10 + 8'(r * 5 + k));
      for (int k = 0; k < 5; k++) begin
        cyc(1'b0, 1'b1, 8'h00);
        check($sformatf("wrap_data%0d_%0d", r, k), s_data_out, 8'h10 + 8'(r * 5 + k));
      end
    end
    check("wrap_empty", s_empty, 1);
    check("wrap_err",   s_err, 0);

    // Simultaneous push+pop at full: count stays 8, oldest out, no overflow.
    for (int i = 0; i < 8; i++) cyc(1'b1, 1'b0, 8'hC0 + 8'(i));
    cyc(1'b1, 1'b1, 8'hD0);
    check("pp_full_lvl",   s_fill, 8);
    check("pp_full_valid", s_valid, 1);
    check("pp_full_data",  s_data_out, 8'hC0);
    check("pp_full_ovf",   s_ovf, 0);
    check("pp_full_err",   s_err, 0);
    for (int i = 1; i < 9; i++) begin
      cyc(1'b0, 1'b1, 8'h00);
      check($sformatf("pp_drain%0d", i), s_data_out, (i < 8) ? 8'hC0 + 8'(i) : 8'hD0);
    end
    check("pp_drain_empty", s_empty, 1);

    // Simultaneous push+pop at empty: push taken, underflow, sticky ERROR.
    cyc(1'b1, 1'b1, 8'hE0);
    check("pp_empty_lvl",   s_fill, 1);
    check("pp_empty_unf",   s_unf, 1);
    check("pp_empty_err",   s_err, 1);
    check("pp_empty_valid", s_valid, 0);
    cyc(1'b1, 1'b0, 8'hE1);
    check("err_push_lvl",   s_fill, 1);
    check("err_unf_pulse",  s_unf, 0);
    check("err_ovf",        s_ovf, 0);
    check("err_sticky",     s_err, 1);
    cyc(1'b0, 1'b1, 8'h00);
    check("err_pop_valid",  s_valid, 0);
    check("err_pop_lvl",    s_fill, 1);

    // Pulse-error instance: overflow at full; threshold 0 disables PAUSE.
    umbral_almost_full = 4'd0;
    do_reset();
    for (int i = 0; i < 8; i++) cyc(1'b1, 1'b0, 8'hB0 + 8'(i));
    check("np_full",   p_full, 1);
    check("np_af_off", p_af, 0);
    cyc(1'b1, 1'b0, 8'hBF);
    check("np_ovf",    p_ovf, 1);
    check("np_err",    p_err, 1);
    check("np_lvl",    p_fill, 8);
    cyc(1'b0, 1'b0, 8'h00);
    check("np_ovf_end", p_ovf, 0);
    check("np_err_end", p_err, 0);
    cyc(1'b0, 1'b1, 8'h00);
    check("np_pop_valid", p_valid, 1);
    check("np_pop_data",  p_data_out, 8'hB0);

    // Reset mid-stream at count 5 (threshold 4 so PAUSE is active).
    umbral_almost_full = 4'd4;
    do_reset();
    for (int i = 0; i < 5; i++) cyc(1'b1, 1'b0, 8'h70 + 8'(i));
    check("mid_lvl5", s_fill, 5);
    check("mid_af",   s_af, 1);
    do_reset();
    check("mid_rst_lvl",   s_fill, 0);
    check("mid_rst_empty", s_empty, 1);
    check("mid_rst_af",    s_af, 0);
    check("mid_rst_err",   s_err, 0);
    cyc(1'b1, 1'b0, 8'h5A);
    cyc(1'b0, 1'b1, 8'h00);
    check("mid_5a_valid", s_valid, 1);
    check("mid_5a_data",  s_data_out, 8'h5A);
    check("mid_5a_empty", s_empty, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
